// File: rtl/systolic_pe_tile.sv
// Output-stationary systolic MAC processing element: accumulates K_LEN valid beats
// of a_in*b_in into one dot product and forwards operands east/south with one cycle of latency.
//
// state | meaning
// IDLE  | no beats taken in the current tile (cnt=0, acc=0)
// ACCUM | 0 < cnt < K_LEN beats accumulated
module systolic_pe_tile #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  parameter int K_LEN    = 4,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              valid_out,
  output logic [ACC_W-1:0]  y_out,
  output logic              y_valid,
  output logic              overflow
);

  localparam int CNT_W = (K_LEN > 1) ? $clog2(K_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(K_LEN - 1);
  localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [ACC_W-1:0]    acc, acc_nxt, acc_base, y_nxt, sum_fit;
  logic                ovf_acc, ovf_acc_nxt, y_valid_nxt, overflow_nxt, ovf_this;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W:0]      prod_ext, acc_ext, sum;

  // One extra sum bit makes overflow visible before the result is narrowed back to ACC_W.
  always_comb begin
    acc_base = (state == IDLE) ? '0 : acc;
    if (SIGNED != 0) begin
      prod     = $signed({{DATA_W{a_in[DATA_W-1]}}, a_in}) *
                 $signed({{DATA_W{b_in[DATA_W-1]}}, b_in});
      prod_ext = {{(ACC_W+1-2*DATA_W){prod[2*DATA_W-1]}}, prod};
      acc_ext  = {acc_base[ACC_W-1], acc_base};
    end else begin
      prod     = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, b_in};
      prod_ext = {{(ACC_W+1-2*DATA_W){1'b0}}, prod};
      acc_ext  = {1'b0, acc_base};
    end
    sum      = acc_ext + prod_ext;
    ovf_this = (SIGNED != 0) ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
    if (ovf_this && (SATURATE != 0))
      sum_fit = (SIGNED != 0) ? (sum[ACC_W] ? S_MIN : S_MAX) : '1;
    else
      sum_fit = sum[ACC_W-1:0];
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    acc_nxt      = acc;
    ovf_acc_nxt  = ovf_acc;
    y_nxt        = y_out;
    y_valid_nxt  = 1'b0;
    overflow_nxt = overflow;
    if (valid_in) begin
      if (cnt == LAST) begin
        y_nxt        = sum_fit;
        y_valid_nxt  = 1'b1;
        overflow_nxt = ovf_acc | ovf_this;
        acc_nxt      = '0;
        cnt_nxt      = '0;
        ovf_acc_nxt  = 1'b0;
        state_nxt    = IDLE;
      end else begin
        acc_nxt      = sum_fit;
        cnt_nxt      = cnt + CNT_W'(1);
        ovf_acc_nxt  = ovf_acc | ovf_this;
        state_nxt    = ACCUM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      ovf_acc   <= 1'b0;
      y_out     <= '0;
      y_valid   <= 1'b0;
      overflow  <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      valid_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      acc       <= acc_nxt;
      ovf_acc   <= ovf_acc_nxt;
      y_out     <= y_nxt;
      y_valid   <= y_valid_nxt;
      overflow  <= overflow_nxt;
      valid_out <= valid_in;
      if (valid_in) begin
        a_out <= a_in;
        b_out <= b_in;
      end
    end
  end

endmodule

// File: tb/tb_systolic_pe_tile.sv
// Bench for systolic_pe_tile: five parameter variants share one stimulus stream and are
// compared each cycle against an arithmetic model, plus directed vector table and reset sequence.
module tb_systolic_pe_tile;

  function automatic int p_aw(int g);  return (g == 0) ? 32 : 16; endfunction
  function automatic int p_k(int g);   return (g == 3) ? 3 : ((g == 4) ? 1 : 4); endfunction
  function automatic int p_sg(int g);  return (g == 3) ? 0 : 1; endfunction
  function automatic int p_sat(int g); return (g == 2 || g == 4) ? 0 : 1; endfunction

  logic       clk, reset, valid_in;
  logic [7:0] a_in, b_in;
  logic [7:0] ao [5];
  logic [7:0] bo [5];
  logic       vo [5];
  logic       dyv [5];
  logic       dov [5];
  logic [63:0] dy [5];

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int AW = p_aw(g);
    logic [AW-1:0] y;
    systolic_pe_tile #(
      .DATA_W(8), .ACC_W(AW), .K_LEN(p_k(g)), .SIGNED(p_sg(g)), .SATURATE(p_sat(g))
    ) u_dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .a_in(a_in), .b_in(b_in),
      .a_out(ao[g]), .b_out(bo[g]), .valid_out(vo[g]),
      .y_out(y), .y_valid(dyv[g]), .overflow(dov[g])
    );
    assign dy[g] = {{(64-AW){1'b0}}, y};
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // reference model state
  longint     m_acc [5];
  int         m_cnt [5];
  bit         m_ovf [5];
  longint     m_y   [5];
  bit         m_yv  [5];
  bit         m_ovo [5];
  logic [7:0] m_a, m_b;
  bit         m_v;

  function automatic logic [63:0] msk(int g, longint v);
    return 64'(v) & ((64'd1 << p_aw(g)) - 64'd1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input logic [7:0] a, input logic [7:0] b);
    longint pa, pb, s, lo, hi, m, res;
    byte    sa, sb;
    bit     o;
    if (r) begin
      for (int g = 0; g < 5; g++) begin
        m_acc[g] = 0; m_cnt[g] = 0; m_ovf[g] = 0; m_y[g] = 0; m_yv[g] = 0; m_ovo[g] = 0;
      end
      m_a = 0; m_b = 0; m_v = 0;
      return;
    end
    m_v = v;
    if (v) begin m_a = a; m_b = b; end
    sa = a; sb = b;
    for (int g = 0; g < 5; g++) begin
      m_yv[g] = 0;
      if (!v) continue;
      pa = (p_sg(g) != 0) ? longint'(sa) : longint'(a);
      pb = (p_sg(g) != 0) ? longint'(sb) : longint'(b);
      s  = m_acc[g] + pa * pb;
      m  = (longint'(1) <<< p_aw(g)) - 1;
      hi = (p_sg(g) != 0) ? (longint'(1) <<< (p_aw(g) - 1)) - 1 : m;
      lo = (p_sg(g) != 0) ? -(longint'(1) <<< (p_aw(g) - 1)) : 0;
      o  = (s < lo) || (s > hi);
      if (!o) res = s;
      else if (p_sat(g) != 0) res = (s < lo) ? lo : hi;
      else begin
        res = s & m;
        if (res > hi) res = res - (m + 1);
      end
      if (m_cnt[g] == p_k(g) - 1) begin
        m_y[g] = res; m_yv[g] = 1; m_ovo[g] = m_ovf[g] | o;
        m_acc[g] = 0; m_cnt[g] = 0; m_ovf[g] = 0;
      end else begin
        m_acc[g] = res; m_cnt[g]++; m_ovf[g] |= o;
      end
    end
  endtask

  task automatic check_all();
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("m%0d_yv", g),  {63'd0, dyv[g]}, {63'd0, m_yv[g]});
      chk($sformatf("m%0d_y", g),   dy[g], msk(g, m_y[g]));
      chk($sformatf("m%0d_ovf", g), {63'd0, dov[g]}, {63'd0, m_ovo[g]});
      chk($sformatf("m%0d_vo", g),  {63'd0, vo[g]}, {63'd0, m_v});
    end
    chk("m_aout", {56'd0, ao[0]}, {56'd0, m_a});
    chk("m_bout", {56'd0, bo[0]}, {56'd0, m_b});
  endtask

  task automatic cycle(input bit r, input bit v, input logic [7:0] a, input logic [7:0] b);
    reset = r; valid_in = v; a_in = a; b_in = b;
    @(posedge clk);
    model_step(r, v, a, b);
    #1;
    check_all();
  endtask

  typedef struct {
    bit v; int a; int b; bit yv;
    longint y0; bit o0; longint y1; bit o1; longint y2; bit o2;
  } vec_t;

  vec_t tbl [22];

  initial begin
    tbl[0]  = '{1, 3, 4, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, -2, 5, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 7, -1, 0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 1, 1, 1, -4, 0, -4, 0, -4, 0};
    for (int i = 6; i < 9; i++) tbl[i] = '{1, 127, 127, 0, -4, 0, -4, 0, -4, 0};
    tbl[9]  = '{1, 127, 127, 1, 64516, 0, 32767, 1, -1020, 1};
    for (int i = 10; i < 13; i++) tbl[i] = '{1, 1, 1, 0, 64516, 0, 32767, 1, -1020, 1};
    tbl[13] = '{1, 1, 1, 1, 4, 0, 4, 0, 4, 0};
    for (int i = 14; i < 17; i++) tbl[i] = '{1, 2, 3, 0, 4, 0, 4, 0, 4, 0};
    tbl[17] = '{1, 2, 3, 1, 24, 0, 24, 0, 24, 0};
    for (int i = 18; i < 21; i++) tbl[i] = '{1, 2, 3, 0, 24, 0, 24, 0, 24, 0};
    tbl[21] = '{1, 2, 3, 1, 24, 0, 24, 0, 24, 0};

    cycle(1, 0, 8'd0, 8'd0);
    cycle(1, 1, 8'h55, 8'haa);
    chk("rst_y",    dy[0], 64'd0);
    chk("rst_yv",   {63'd0, dyv[0]}, 64'd0);
    chk("rst_ovf",  {63'd0, dov[0]}, 64'd0);
    chk("rst_aout", {56'd0, ao[0]}, 64'd0);
    chk("rst_vo",   {63'd0, vo[0]}, 64'd0);

    for (int i = 0; i < 22; i++) begin
      cycle(0, tbl[i].v, 8'(tbl[i].a), 8'(tbl[i].b));
      for (int g = 0; g < 3; g++)
        chk($sformatf("tbl%0d_yv%0d", i, g), {63'd0, dyv[g]}, {63'd0, tbl[i].yv});
      chk($sformatf("tbl%0d_y0", i), dy[0], msk(0, tbl[i].y0));
      chk($sformatf("tbl%0d_o0", i), {63'd0, dov[0]}, {63'd0, tbl[i].o0});
      chk($sformatf("tbl%0d_y1", i), dy[1], msk(1, tbl[i].y1));
      chk($sformatf("tbl%0d_o1", i), {63'd0, dov[1]}, {63'd0, tbl[i].o1});
      chk($sformatf("tbl%0d_y2", i), dy[2], msk(2, tbl[i].y2));
      chk($sformatf("tbl%0d_o2", i), {63'd0, dov[2]}, {63'd0, tbl[i].o2});
      if (!tbl[i].v && i > 0)
        chk($sformatf("tbl%0d_ahold", i), {56'd0, ao[0]}, {56'd0, 8'(tbl[i-1].a)});
    end

    // reset in the middle of a tile drops the partial sum
    cycle(0, 1, 8'd5, 8'd5);
    cycle(0, 1, 8'd5, 8'd5);
    cycle(1, 1, 8'd9, 8'd9);
    chk("midrst_y",    dy[0], 64'd0);
    chk("midrst_yv",   {63'd0, dyv[0]}, 64'd0);
    chk("midrst_aout", {56'd0, ao[0]}, 64'd0);
    chk("midrst_vo",   {63'd0, vo[0]}, 64'd0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 8'd1, 8'd1);
    chk("midrst_y_hold", dy[0], 64'd0);
    cycle(0, 1, 8'd1, 8'd1);
    chk("midrst_y4",  dy[0], 64'd4);
    chk("midrst_yv4", {63'd0, dyv[0]}, 64'd1);
    chk("vo_high",    {63'd0, vo[0]}, 64'd1);
    cycle(0, 0, 8'd0, 8'd0);
    chk("vo_low",     {63'd0, vo[0]}, 64'd0);
    chk("yv_pulse",   {63'd0, dyv[0]}, 64'd0);

    for (int n = 0; n < 3000; n++) begin
      logic [7:0] ra, rb;
      logic [7:0] ext [3];
      ext[0] = 8'h7f; ext[1] = 8'h80; ext[2] = 8'hff;
      ra = ($urandom_range(0, 3) == 0) ? ext[$urandom_range(0, 2)] : 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ext[$urandom_range(0, 2)] : 8'($urandom);
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
